// File: rtl/id_ex_stage_reg_if.sv
// Decoded-instruction bundle: driven by ID into the ID/EX register,
// and driven by the ID/EX register into EX and the forwarding unit.
interface id_ex_stage_reg_if #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
);
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;

    modport master (
        output valid, pc, rs1_data, rs2_data, imm, rs1, rs2, rd,
               uses_rs1, uses_rs2, reg_write, mem_read, mem_write,
               mem_to_reg, alu_src, alu_op
    );

    modport slave (
        input  valid, pc, rs1_data, rs2_data, imm, rs1, rs2, rd,
               uses_rs1, uses_rs2, reg_write, mem_read, mem_write,
               mem_to_reg, alu_src, alu_op
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles
// and a saturating count of load-use stall bubbles.
module id_ex_stage_reg #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    id_ex_stage_reg_if.slave  id_bus,
    id_ex_stage_reg_if.master ex_bus,
    output logic              hold_if_id,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic               uses_rs1;
        logic               uses_rs2;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } stage_t;

    stage_t             stage_in;
    stage_t             stage_p1_d;
    stage_t             stage_p1_q;
    logic               vld_p1_d;
    logic               vld_p1_q;
    logic [CNT_W-1:0]   stall_count_d;
    logic [CNT_W-1:0]   stall_count_q;
    logic               rs1_hit;
    logic               rs2_hit;
    logic               load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    always_comb begin
        stage_in.pc         = id_bus.pc;
        stage_in.rs1_data   = id_bus.rs1_data;
        stage_in.rs2_data   = id_bus.rs2_data;
        stage_in.imm        = id_bus.imm;
        stage_in.rs1        = id_bus.rs1;
        stage_in.rs2        = id_bus.rs2;
        stage_in.rd         = id_bus.rd;
        stage_in.uses_rs1   = id_bus.uses_rs1;
        stage_in.uses_rs2   = id_bus.uses_rs2;
        stage_in.reg_write  = id_bus.reg_write;
        stage_in.mem_read   = id_bus.mem_read;
        stage_in.mem_write  = id_bus.mem_write;
        stage_in.mem_to_reg = id_bus.mem_to_reg;
        stage_in.alu_src    = id_bus.alu_src;
        stage_in.alu_op     = id_bus.alu_op;
    end

    // A load with rd=x0 never produces a value, so it can never cause a stall.
    always_comb begin
        rs1_hit  = id_bus.uses_rs1 && (id_bus.rs1 == stage_p1_q.rd);
        rs2_hit  = id_bus.uses_rs2 && (id_bus.rs2 == stage_p1_q.rd);
        load_use = vld_p1_q && stage_p1_q.mem_read && (stage_p1_q.rd != 5'd0) &&
                   id_bus.valid && (rs1_hit || rs2_hit);
        hold_if_id = load_use && !flush;
    end

    // Flush outranks the hazard: a wrong-path instruction neither stalls nor counts.
    always_comb begin
        stage_p1_d    = stage_in;
        vld_p1_d      = 1'b1;
        stall_count_d = stall_count_q;
        if (flush) begin
            stage_p1_d = '0;
            vld_p1_d   = 1'b0;
        end else if (load_use) begin
            stage_p1_d    = '0;
            vld_p1_d      = 1'b0;
            stall_count_d = sat_inc(stall_count_q);
        end else if (!id_bus.valid) begin
            stage_p1_d = '0;
            vld_p1_d   = 1'b0;
        end
    end

    // ID -> EX stage boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_p1_q    <= '0;
            vld_p1_q      <= 1'b0;
            stall_count_q <= '0;
        end else begin
            stage_p1_q    <= stage_p1_d;
            vld_p1_q      <= vld_p1_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ex_bus.valid      = vld_p1_q;
    assign ex_bus.pc         = stage_p1_q.pc;
    assign ex_bus.rs1_data   = stage_p1_q.rs1_data;
    assign ex_bus.rs2_data   = stage_p1_q.rs2_data;
    assign ex_bus.imm        = stage_p1_q.imm;
    assign ex_bus.rs1        = stage_p1_q.rs1;
    assign ex_bus.rs2        = stage_p1_q.rs2;
    assign ex_bus.rd         = stage_p1_q.rd;
    assign ex_bus.uses_rs1   = stage_p1_q.uses_rs1;
    assign ex_bus.uses_rs2   = stage_p1_q.uses_rs2;
    assign ex_bus.reg_write  = stage_p1_q.reg_write;
    assign ex_bus.mem_read   = stage_p1_q.mem_read;
    assign ex_bus.mem_write  = stage_p1_q.mem_write;
    assign ex_bus.mem_to_reg = stage_p1_q.mem_to_reg;
    assign ex_bus.alu_src    = stage_p1_q.alu_src;
    assign ex_bus.alu_op     = stage_p1_q.alu_op;
    assign stall_count       = stall_count_q;

endmodule
